// File: rtl/writeback_stage.sv
// ---------------------------------------------------------------------------
// writeback_stage
//
// MIPS write-back stage and write-side driver of the register file. It holds
// one MEM/WB entry, forms the final register value (ALU result, or the
// big-endian extracted and extended load data) at capture time, and presents
// that value to the register file once per retired instruction. The held
// value is also exported as a bypass source, and every retirement is counted.
//
// Ports
//   Clk, Reset        rising-edge clock, synchronous active-high reset
//   inValid/inReady   MEM -> WB handshake
//   inDest            destination register index
//   inRegWrite        instruction writes a register
//   inMemToReg        1 = load data, 0 = ALU result
//   inLoadSize        00 word, 01 halfword, 10 byte, 11 word
//   inLoadUnsigned    zero-extend (1) / sign-extend (0) sub-word loads
//   inByteOffset      load address bits [1:0]
//   inAluResult       ALU result
//   inMemData         raw word read from data memory
//   holdWb            freeze; the held entry is not consumed
//   rd/writeSig/writeData   register file write port
//   fwdValid/fwdDest/fwdData bypass value for operand forwarding
//   alignErr          held load is misaligned (retires without writing)
//   retireCount       retired-instruction counter (wraps)
//
// Handshake: a transfer into the stage happens on a rising edge where
// inValid && inReady. inReady = !validQ || !holdWb, so a held entry that is
// being consumed in the same cycle frees the slot for the next instruction
// (one instruction per cycle). The held entry is consumed on any edge where
// validQ && !holdWb; inValid does not depend on inReady.
// ---------------------------------------------------------------------------
module writeback_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  inValid,
    output logic                  inReady,
    input  logic [REG_ADDR_W-1:0] inDest,
    input  logic                  inRegWrite,
    input  logic                  inMemToReg,
    input  logic [1:0]            inLoadSize,
    input  logic                  inLoadUnsigned,
    input  logic [1:0]            inByteOffset,
    input  logic [DATA_W-1:0]     inAluResult,
    input  logic [DATA_W-1:0]     inMemData,
    input  logic                  holdWb,
    output logic [REG_ADDR_W-1:0] rd,
    output logic                  writeSig,
    output logic [DATA_W-1:0]     writeData,
    output logic                  fwdValid,
    output logic [REG_ADDR_W-1:0] fwdDest,
    output logic [DATA_W-1:0]     fwdData,
    output logic                  alignErr,
    output logic [31:0]           retireCount
);

    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;

    // Held MEM/WB entry
    logic                  validQ;
    logic [REG_ADDR_W-1:0] destQ;
    logic                  regWriteQ;
    logic [DATA_W-1:0]     resultQ;
    logic                  misalignQ;
    logic [31:0]           countQ;

    logic                  captureEn;
    logic                  consumeEn;
    logic                  destNonZero;
    logic                  writesReg;

    // Load extraction
    logic [15:0]           loadHalf;
    logic [7:0]            loadByte;
    logic                  extSign;
    logic [DATA_W-1:0]     loadValue;
    logic                  loadMisalign;
    logic [DATA_W-1:0]     nextResult;
    logic                  nextMisalign;

    // -----------------------------------------------------------------------
    // Handshake
    // -----------------------------------------------------------------------
    assign inReady   = !validQ || !holdWb;
    assign captureEn = inValid && inReady;
    assign consumeEn = validQ && !holdWb;

    // -----------------------------------------------------------------------
    // Result formation. Memory is big-endian: the lowest address (offset 0)
    // is the most significant byte of the word.
    // -----------------------------------------------------------------------
    always_comb begin
        loadHalf     = inByteOffset[1] ? inMemData[15:0] : inMemData[31:16];
        loadByte     = 8'h00;
        extSign      = 1'b0;
        loadValue    = inMemData;
        loadMisalign = 1'b0;

        case (inByteOffset)
            2'd0:    loadByte = inMemData[31:24];
            2'd1:    loadByte = inMemData[23:16];
            2'd2:    loadByte = inMemData[15:8];
            default: loadByte = inMemData[7:0];
        endcase

        case (inLoadSize)
            SIZE_HALF: begin
                extSign      = !inLoadUnsigned && loadHalf[15];
                loadValue    = {{(DATA_W-16){extSign}}, loadHalf};
                loadMisalign = inByteOffset[0];
            end
            SIZE_BYTE: begin
                extSign      = !inLoadUnsigned && loadByte[7];
                loadValue    = {{(DATA_W-8){extSign}}, loadByte};
                loadMisalign = 1'b0;
            end
            default: begin
                // Word, and the reserved encoding 11 behaves as word.
                loadValue    = inMemData;
                loadMisalign = (inByteOffset != 2'b00);
            end
        endcase
    end

    // Misalignment only means something for loads; ALU results are never
    // flagged regardless of what the offset bits happen to carry.
    assign nextResult   = inMemToReg ? loadValue : inAluResult;
    assign nextMisalign = inMemToReg && loadMisalign;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            validQ    <= 1'b0;
            destQ     <= '0;
            regWriteQ <= 1'b0;
            resultQ   <= '0;
            misalignQ <= 1'b0;
            countQ    <= '0;
        end else begin
            // Capture wins over consume: in a same-cycle capture+consume the
            // old entry retires at this edge and the new one takes its slot.
            if (captureEn) begin
                validQ    <= 1'b1;
                destQ     <= inDest;
                regWriteQ <= inRegWrite;
                resultQ   <= nextResult;
                misalignQ <= nextMisalign;
            end else if (consumeEn) begin
                validQ    <= 1'b0;
            end

            if (consumeEn) begin
                countQ <= countQ + 32'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign destNonZero = (destQ != '0);
    // Register 0 is hard-wired zero and misaligned loads never commit.
    assign writesReg   = regWriteQ && destNonZero && !misalignQ;

    assign rd          = destQ;
    assign writeData   = resultQ;
    // Only the consuming cycle writes, so a held entry cannot write twice.
    assign writeSig    = consumeEn && writesReg;

    // The bypass stays live while held so dependents can still forward.
    assign fwdValid    = validQ && writesReg;
    assign fwdDest     = destQ;
    assign fwdData     = resultQ;

    assign alignErr    = validQ && misalignQ;
    assign retireCount = countQ;

endmodule

// File: tb/tb_writeback_stage.sv
// ---------------------------------------------------------------------------
// tb_writeback_stage
//
// Directed bench for writeback_stage. A reference model keeps the held entry
// as a 0/1-element queue with values formed by shift-and-mask arithmetic; a
// compare process checks every output on each falling edge. Hand-computed
// register writes are queued by the stimulus and matched in order against
// every writeSig pulse; hand-computed pins check individual outputs.
// ---------------------------------------------------------------------------
module tb_writeback_stage;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    localparam int SEL_READY   = 0;
    localparam int SEL_WSIG    = 1;
    localparam int SEL_RD      = 2;
    localparam int SEL_WDATA   = 3;
    localparam int SEL_FVALID  = 4;
    localparam int SEL_FDEST   = 5;
    localparam int SEL_FDATA   = 6;
    localparam int SEL_ALIGN   = 7;
    localparam int SEL_COUNT   = 8;
    localparam int SEL_PENDING = 9;
    localparam int SEL_EXPW    = 10;

    // -----------------------------------------------------------------------
    // DUT signals
    // -----------------------------------------------------------------------
    logic                  Clk;
    logic                  Reset;
    logic                  inValid;
    logic                  inReady;
    logic [REG_ADDR_W-1:0] inDest;
    logic                  inRegWrite;
    logic                  inMemToReg;
    logic [1:0]            inLoadSize;
    logic                  inLoadUnsigned;
    logic [1:0]            inByteOffset;
    logic [DATA_W-1:0]     inAluResult;
    logic [DATA_W-1:0]     inMemData;
    logic                  holdWb;
    logic [REG_ADDR_W-1:0] rd;
    logic                  writeSig;
    logic [DATA_W-1:0]     writeData;
    logic                  fwdValid;
    logic [REG_ADDR_W-1:0] fwdDest;
    logic [DATA_W-1:0]     fwdData;
    logic                  alignErr;
    logic [31:0]           retireCount;

    writeback_stage #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) dut (
        .Clk(Clk), .Reset(Reset),
        .inValid(inValid), .inReady(inReady),
        .inDest(inDest), .inRegWrite(inRegWrite), .inMemToReg(inMemToReg),
        .inLoadSize(inLoadSize), .inLoadUnsigned(inLoadUnsigned),
        .inByteOffset(inByteOffset), .inAluResult(inAluResult),
        .inMemData(inMemData), .holdWb(holdWb),
        .rd(rd), .writeSig(writeSig), .writeData(writeData),
        .fwdValid(fwdValid), .fwdDest(fwdDest), .fwdData(fwdData),
        .alignErr(alignErr), .retireCount(retireCount)
    );

    // -----------------------------------------------------------------------
    // Clock / watchdog
    // -----------------------------------------------------------------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // -----------------------------------------------------------------------
    // Reference model
    // -----------------------------------------------------------------------
    typedef struct {
        logic [REG_ADDR_W-1:0] dest;
        logic                  regWrite;
        logic [31:0]           result;
        logic                  misalign;
    } entry_t;

    entry_t      held[$];
    logic [31:0] mCount = 0;
    int          preloadReq  = 0;
    int          preloadSeen = 0;

    function automatic entry_t formEntry(logic [REG_ADDR_W-1:0] dest,
                                         logic rw, logic m2r, logic [1:0] size,
                                         logic uns, logic [1:0] off,
                                         logic [31:0] alu, logic [31:0] mem);
        entry_t      e;
        logic [31:0] v;
        int          sh;
        e.dest = dest;
        e.regWrite = rw;
        e.misalign = 1'b0;
        if (!m2r) begin
            e.result = alu;
        end else if (size == 2'b01) begin
            sh = off[1] ? 0 : 16;
            v = (mem >> sh) & 32'h0000FFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF0000;
            e.result = v;
            e.misalign = off[0];
        end else if (size == 2'b10) begin
            sh = 8 * (3 - int'(off));
            v = (mem >> sh) & 32'h000000FF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFFFF00;
            e.result = v;
        end else begin
            e.result = mem;
            e.misalign = (off != 2'b00);
        end
        return e;
    endfunction

    always @(posedge Clk) begin
        bit slotFree;
        if (preloadReq != preloadSeen) begin
            mCount = 32'hFFFFFFFF;
            preloadSeen = preloadReq;
        end
        if (Reset) begin
            held.delete();
            mCount = 0;
        end else begin
            slotFree = (held.size() == 0) || !holdWb;
            if (held.size() != 0 && !holdWb) begin
                void'(held.pop_front());
                mCount = mCount + 1;
            end
            if (inValid && slotFree)
                held.push_back(formEntry(inDest, inRegWrite, inMemToReg, inLoadSize,
                                         inLoadUnsigned, inByteOffset, inAluResult, inMemData));
        end
    end

    // -----------------------------------------------------------------------
    // Pin request ring (stimulus writes, compare process reads)
    // -----------------------------------------------------------------------
    string       pinName [256];
    int          pinSel  [256];
    logic [31:0] pinVal  [256];
    logic [4:0]  pinDst  [256];
    int          pinWr = 0;
    int          pinRd = 0;
    logic        checking = 1'b0;

    task automatic pin(input string name, input int sel, input logic [31:0] val);
        pinName[pinWr % 256] = name;
        pinSel[pinWr % 256]  = sel;
        pinVal[pinWr % 256]  = val;
        pinDst[pinWr % 256]  = 5'd0;
        pinWr = pinWr + 1;
    endtask

    task automatic expw(input logic [4:0] dest, input logic [31:0] val);
        pinName[pinWr % 256] = "expw";
        pinSel[pinWr % 256]  = SEL_EXPW;
        pinVal[pinWr % 256]  = val;
        pinDst[pinWr % 256]  = dest;
        pinWr = pinWr + 1;
    endtask

    // -----------------------------------------------------------------------
    // Scoreboard / compare process
    // -----------------------------------------------------------------------
    logic [36:0] exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s @%0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] pick(input int sel);
        case (sel)
            SEL_READY:  return {31'b0, inReady};
            SEL_WSIG:   return {31'b0, writeSig};
            SEL_RD:     return {27'b0, rd};
            SEL_WDATA:  return writeData;
            SEL_FVALID: return {31'b0, fwdValid};
            SEL_FDEST:  return {27'b0, fwdDest};
            SEL_FDATA:  return fwdData;
            SEL_ALIGN:  return {31'b0, alignErr};
            SEL_COUNT:  return retireCount;
            default:    return 32'hDEADBEEF;
        endcase
    endfunction

    always @(negedge Clk) begin
        logic        eV, eReady, eWr, eFwd, eErr;
        logic [36:0] w;
        entry_t      e;
        if (checking) begin
            while (pinRd != pinWr) begin
                if (pinSel[pinRd % 256] == SEL_EXPW)
                    exp_q.push_back({pinDst[pinRd % 256], pinVal[pinRd % 256]});
                else if (pinSel[pinRd % 256] == SEL_PENDING)
                    checkVal(pinName[pinRd % 256], exp_q.size(), pinVal[pinRd % 256]);
                else
                    checkVal(pinName[pinRd % 256], pick(pinSel[pinRd % 256]), pinVal[pinRd % 256]);
                pinRd = pinRd + 1;
            end

            eV = (held.size() != 0);
            e  = eV ? held[0] : '{dest: 5'd0, regWrite: 1'b0, result: 32'd0, misalign: 1'b0};
            eFwd   = eV && e.regWrite && (e.dest != 0) && !e.misalign;
            eWr    = eFwd && !holdWb;
            eErr   = eV && e.misalign;
            eReady = !eV || !holdWb;
            checkVal("model_inReady",  {31'b0, inReady},  {31'b0, eReady});
            checkVal("model_writeSig", {31'b0, writeSig}, {31'b0, eWr});
            checkVal("model_fwdValid", {31'b0, fwdValid}, {31'b0, eFwd});
            checkVal("model_alignErr", {31'b0, alignErr}, {31'b0, eErr});
            checkVal("model_retire",   retireCount,       mCount);
            if (eWr) begin
                checkVal("model_rd",        {27'b0, rd},        {27'b0, e.dest});
                checkVal("model_writeData", writeData,          e.result);
            end
            if (eFwd) begin
                checkVal("model_fwdDest", {27'b0, fwdDest}, {27'b0, e.dest});
                checkVal("model_fwdData", fwdData,          e.result);
            end

            if (writeSig) begin
                if (exp_q.size() == 0) begin
                    checkVal("unexpected_write", {27'b0, rd}, 32'hFFFFFFFF);
                end else begin
                    w = exp_q.pop_front();
                    checkVal("sb_rd",        {27'b0, rd}, {27'b0, w[36:32]});
                    checkVal("sb_writeData", writeData,   w[31:0]);
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Driver tasks
    // -----------------------------------------------------------------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic setIn(input logic [4:0] dest, input logic rw, input logic m2r,
                         input logic [1:0] size, input logic uns, input logic [1:0] off,
                         input logic [31:0] alu, input logic [31:0] mem);
        inValid = 1'b1;
        inDest = dest;
        inRegWrite = rw;
        inMemToReg = m2r;
        inLoadSize = size;
        inLoadUnsigned = uns;
        inByteOffset = off;
        inAluResult = alu;
        inMemData = mem;
    endtask

    // Presents one instruction and returns 1 ns after the capturing edge.
    task automatic issue(input logic [4:0] dest, input logic rw, input logic m2r,
                         input logic [1:0] size, input logic uns, input logic [1:0] off,
                         input logic [31:0] alu, input logic [31:0] mem);
        logic rdy;
        int   tries;
        setIn(dest, rw, m2r, size, uns, off, alu, mem);
        tries = 0;
        do begin
            @(negedge Clk);
            rdy = inReady;
            @(posedge Clk);
            #1;
            tries = tries + 1;
            if (tries > 50) begin
                $display("FAIL issue_timeout: got no capture expected capture within 50 cycles");
                $fatal(1, "capture timeout");
            end
        end while (!rdy);
        inValid = 1'b0;
    endtask

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        Reset = 1'b1;
        holdWb = 1'b0;
        setIn(5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'd0, 32'd0);
        inValid = 1'b0;
        idle(2);
        Reset = 1'b0;
        checking = 1'b1;

        // Reset state
        pin("rst_inReady", SEL_READY, 1);
        pin("rst_writeSig", SEL_WSIG, 0);
        pin("rst_rd", SEL_RD, 0);
        pin("rst_writeData", SEL_WDATA, 0);
        pin("rst_fwdValid", SEL_FVALID, 0);
        pin("rst_fwdDest", SEL_FDEST, 0);
        pin("rst_fwdData", SEL_FDATA, 0);
        pin("rst_alignErr", SEL_ALIGN, 0);
        pin("rst_retire", SEL_COUNT, 0);
        idle(1);

        // ALU op to r8
        expw(5'd8, 32'd456);
        issue(5'd8, 1, 0, 2'b00, 0, 2'b00, 32'd456, 32'h0);
        pin("alu_wsig", SEL_WSIG, 1);
        pin("alu_rd", SEL_RD, 8);
        pin("alu_wdata", SEL_WDATA, 456);
        pin("alu_retire_pre", SEL_COUNT, 0);
        idle(1);
        pin("alu_retire", SEL_COUNT, 1);
        pin("alu_wsig_done", SEL_WSIG, 0);
        idle($urandom_range(1, 2));

        // Load extraction, back to back
        expw(5'd9, 32'hFFFFFFF4);
        issue(5'd9, 1, 1, 2'b10, 0, 2'd1, 32'h0, 32'h12F45678);
        pin("lb_signed", SEL_WDATA, 32'hFFFFFFF4);
        expw(5'd10, 32'h000000F4);
        issue(5'd10, 1, 1, 2'b10, 1, 2'd1, 32'h0, 32'h12F45678);
        pin("lbu", SEL_WDATA, 32'h000000F4);
        expw(5'd11, 32'hFFFFABCD);
        issue(5'd11, 1, 1, 2'b01, 0, 2'd2, 32'h0, 32'h1234ABCD);
        pin("lh_off2", SEL_WDATA, 32'hFFFFABCD);
        expw(5'd12, 32'h00001234);
        issue(5'd12, 1, 1, 2'b01, 1, 2'd0, 32'h0, 32'h1234ABCD);
        pin("lhu_off0", SEL_WDATA, 32'h00001234);
        expw(5'd13, 32'h00000078);
        issue(5'd13, 1, 1, 2'b10, 0, 2'd3, 32'h0, 32'h12F45678);
        pin("lb_off3", SEL_WDATA, 32'h00000078);
        expw(5'd14, 32'h12F45678);
        issue(5'd14, 1, 1, 2'b11, 0, 2'd0, 32'hAAAA5555, 32'h12F45678);
        pin("lw_size3", SEL_WDATA, 32'h12F45678);
        idle($urandom_range(1, 2));
        pin("loads_retire", SEL_COUNT, 7);

        // Write to r0 is suppressed but still retires
        issue(5'd0, 1, 0, 2'b00, 0, 2'b00, 32'd88888, 32'h0);
        pin("r0_wsig", SEL_WSIG, 0);
        pin("r0_fwd", SEL_FVALID, 0);
        idle(1);
        pin("r0_retire", SEL_COUNT, 8);

        // Back-to-back r3/r4/r5 with a 3-cycle hold after the first capture
        expw(5'd3, 32'd333);
        expw(5'd4, 32'd444);
        expw(5'd5, 32'd555);
        setIn(5'd3, 1, 0, 2'b00, 0, 2'b00, 32'd333, 32'h0);
        idle(1);
        setIn(5'd4, 1, 0, 2'b00, 0, 2'b00, 32'd444, 32'h0);
        holdWb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pin("hold_ready", SEL_READY, 0);
            pin("hold_wsig", SEL_WSIG, 0);
            pin("hold_fwdValid", SEL_FVALID, 1);
            pin("hold_fwdDest", SEL_FDEST, 3);
            pin("hold_fwdData", SEL_FDATA, 333);
            idle(1);
        end
        holdWb = 1'b0;
        pin("rel_rd3", SEL_RD, 3);
        pin("rel_wsig3", SEL_WSIG, 1);
        idle(1);
        setIn(5'd5, 1, 0, 2'b00, 0, 2'b00, 32'd555, 32'h0);
        pin("rel_rd4", SEL_RD, 4);
        idle(1);
        inValid = 1'b0;
        pin("rel_rd5", SEL_RD, 5);
        idle(1);
        pin("rel_idle", SEL_WSIG, 0);
        pin("rel_retire", SEL_COUNT, 11);

        // Misaligned halfword
        issue(5'd6, 1, 1, 2'b01, 0, 2'd1, 32'h0, 32'h1234ABCD);
        pin("mis_align", SEL_ALIGN, 1);
        pin("mis_wsig", SEL_WSIG, 0);
        pin("mis_fwd", SEL_FVALID, 0);
        idle(1);
        pin("mis_align_clr", SEL_ALIGN, 0);
        pin("mis_retire", SEL_COUNT, 12);

        // Reset while r7 is held; inValid during reset is not captured
        issue(5'd7, 1, 0, 2'b00, 0, 2'b00, 32'd777, 32'h0);
        holdWb = 1'b1;
        pin("rh_fwd", SEL_FVALID, 1);
        idle(1);
        Reset = 1'b1;
        setIn(5'd7, 1, 0, 2'b00, 0, 2'b00, 32'd999, 32'h0);
        idle(1);
        Reset = 1'b0;
        inValid = 1'b0;
        holdWb = 1'b0;
        pin("rh_ready", SEL_READY, 1);
        pin("rh_wsig", SEL_WSIG, 0);
        pin("rh_rd", SEL_RD, 0);
        pin("rh_wdata", SEL_WDATA, 0);
        pin("rh_fwd0", SEL_FVALID, 0);
        pin("rh_fdata", SEL_FDATA, 0);
        pin("rh_align", SEL_ALIGN, 0);
        pin("rh_retire", SEL_COUNT, 0);
        idle(2);
        pin("rh_retire_idle", SEL_COUNT, 0);

        // Counter wrap: preload to all-ones, then one more retirement
        @(negedge Clk);
        #2;
        force dut.countQ = 32'hFFFFFFFF;
        preloadReq = preloadReq + 1;
        #1;
        release dut.countQ;
        @(posedge Clk);
        #1;
        pin("wrap_pre", SEL_COUNT, 32'hFFFFFFFF);
        expw(5'd9, 32'h99);
        issue(5'd9, 1, 0, 2'b00, 0, 2'b00, 32'h99, 32'h0);
        idle(1);
        pin("wrap_zero", SEL_COUNT, 0);

        pin("pending_writes", SEL_PENDING, 0);
        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
